// File: rtl/delay_prog_ctl.sv
`default_nettype none
// ============================================================================
// Module   : delay_prog_ctl
// Brief    : Programming controller for the tapped delay line: accepts delay
//            requests, issues a one-cycle active-low strobe, tracks settling.
// Revision : 1.0 - initial release
// ============================================================================
module delay_prog_ctl #(
    parameter int D_DEPTH      = 3,
    parameter int SETTLE_EXTRA = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    input  logic [D_DEPTH-1:0] req_delay,
    output logic               req_ready,
    output logic               prog_ctl_,
    output logic [D_DEPTH-1:0] prog_delay,
    output logic [D_DEPTH-1:0] cur_delay,
    output logic               settled,
    output logic               prog_done
);

    localparam int                 c_CNT_W        = D_DEPTH + 1;
    localparam logic [c_CNT_W-1:0] c_SETTLE_EXTRA = c_CNT_W'(SETTLE_EXTRA);
    localparam logic [c_CNT_W-1:0] c_FLUSH_COUNT  = c_CNT_W'((2 ** D_DEPTH) - 1 + SETTLE_EXTRA);
    localparam logic [c_CNT_W-1:0] c_ONE          = c_CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PROG   = 2'd1,
        ST_SETTLE = 2'd2
    } state_t;

    state_t               r_state,    w_state_nxt;
    logic [c_CNT_W-1:0]   r_count,    w_count_nxt;
    logic [D_DEPTH-1:0]   r_target,   w_target_nxt;
    logic [D_DEPTH-1:0]   r_old,      w_old_nxt;
    logic [D_DEPTH-1:0]   r_cur,      w_cur_nxt;
    logic [D_DEPTH-1:0]   r_pdelay,   w_pdelay_nxt;
    logic                 r_prog_n,   w_prog_n_nxt;
    logic                 r_settled,  w_settled_nxt;
    logic                 r_done,     w_done_nxt;
    logic                 r_ready,    w_ready_nxt;

    logic [c_CNT_W-1:0]   w_max;
    logic [c_CNT_W-1:0]   w_k;
    logic                 w_accept;

    // Settle length covers the longer of the old and new tap distances
    assign w_max    = (r_old > r_target) ? {1'b0, r_old} : {1'b0, r_target};
    assign w_k      = w_max + c_SETTLE_EXTRA;
    assign w_accept = req_valid & r_ready;

    always_comb begin
        w_state_nxt   = r_state;
        w_count_nxt   = r_count;
        w_target_nxt  = r_target;
        w_old_nxt     = r_old;
        w_cur_nxt     = r_cur;
        w_pdelay_nxt  = r_pdelay;
        w_settled_nxt = r_settled;
        w_prog_n_nxt  = 1'b1;
        w_done_nxt    = 1'b0;
        w_ready_nxt   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_ready_nxt = 1'b1;
                if (w_accept && (req_delay != r_cur)) begin
                    w_target_nxt  = req_delay;
                    w_old_nxt     = r_cur;
                    w_pdelay_nxt  = req_delay;
                    w_prog_n_nxt  = 1'b0;
                    w_settled_nxt = 1'b0;
                    w_ready_nxt   = 1'b0;
                    w_state_nxt   = ST_PROG;
                end
            end
            ST_PROG: begin
                w_cur_nxt   = r_target;
                w_count_nxt = w_k;
                if (w_k == '0) begin
                    w_settled_nxt = 1'b1;
                    w_ready_nxt   = 1'b1;
                    w_state_nxt   = ST_IDLE;
                end else begin
                    w_state_nxt   = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                // Leaving on the edge where the count steps from 1 to 0
                if (r_count <= c_ONE) begin
                    w_count_nxt   = '0;
                    w_settled_nxt = 1'b1;
                    w_done_nxt    = 1'b1;
                    w_ready_nxt   = 1'b1;
                    w_state_nxt   = ST_IDLE;
                end else begin
                    w_count_nxt   = r_count - c_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_SETTLE;
            r_count   <= c_FLUSH_COUNT;
            r_target  <= '0;
            r_old     <= '0;
            r_cur     <= '0;
            r_pdelay  <= '0;
            r_prog_n  <= 1'b1;
            r_settled <= 1'b0;
            r_done    <= 1'b0;
            r_ready   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_count   <= w_count_nxt;
            r_target  <= w_target_nxt;
            r_old     <= w_old_nxt;
            r_cur     <= w_cur_nxt;
            r_pdelay  <= w_pdelay_nxt;
            r_prog_n  <= w_prog_n_nxt;
            r_settled <= w_settled_nxt;
            r_done    <= w_done_nxt;
            r_ready   <= w_ready_nxt;
        end
    end

    assign req_ready  = r_ready;
    assign prog_ctl_  = r_prog_n;
    assign prog_delay = r_pdelay;
    assign cur_delay  = r_cur;
    assign settled    = r_settled;
    assign prog_done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_delay_prog_ctl.sv
`default_nettype none
// ============================================================================
// Module   : tb_delay_prog_ctl
// Brief    : Timeline-model bench for delay_prog_ctl (directed + random).
// Revision : 1.0 - initial release
// ============================================================================
module tb_delay_prog_ctl;

    localparam int D  = 3;
    localparam int SE = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic [D-1:0] req_delay;
    logic         req_ready;
    logic         prog_ctl_;
    logic [D-1:0] prog_delay;
    logic [D-1:0] cur_delay;
    logic         settled;
    logic         prog_done;

    delay_prog_ctl #(
        .D_DEPTH      (D),
        .SETTLE_EXTRA (SE)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_delay  (req_delay),
        .req_ready  (req_ready),
        .prog_ctl_  (prog_ctl_),
        .prog_delay (prog_delay),
        .cur_delay  (cur_delay),
        .settled    (settled),
        .prog_done  (prog_done)
    );

    always #5 clk = ~clk;

    int cyc       = 0;
    int n_checks  = 0;
    int n_errors  = 0;

    // Timeline model: values "in cycle c" are those visible after edge c
    int m_cur        = 0;
    int m_old        = 0;
    int m_ready_from = 0;
    int m_strobe_at  = -1;
    int m_done_at    = -1;
    bit m_live       = 1'b0;
    bit m_acc        = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step();
        int k;
        @(posedge clk);
        cyc++;
        m_acc = 1'b0;
        if (rst) begin
            m_live       = 1'b1;
            m_cur        = 0;
            m_strobe_at  = -1;
            m_ready_from = cyc + (2 ** D) - 1 + SE;
            m_done_at    = m_ready_from;
        end else if (m_live && req_valid && (cyc - 1 >= m_ready_from)) begin
            m_acc = 1'b1;
            if (int'(req_delay) != m_cur) begin
                m_old        = m_cur;
                m_cur        = int'(req_delay);
                k            = ((m_old > m_cur) ? m_old : m_cur) + SE;
                m_strobe_at  = cyc;
                m_ready_from = cyc + 1 + k;
                m_done_at    = m_ready_from;
            end
        end
        @(negedge clk);
        if (m_live) begin
            check("req_ready",  32'(req_ready),  32'(cyc >= m_ready_from));
            check("settled",    32'(settled),    32'(cyc >= m_ready_from));
            check("prog_done",  32'(prog_done),  32'(cyc == m_done_at));
            check("prog_ctl_",  32'(prog_ctl_),  32'(cyc != m_strobe_at));
            check("cur_delay",  32'(cur_delay),  32'((cyc == m_strobe_at) ? m_old : m_cur));
            check("prog_delay", 32'(prog_delay), 32'(m_cur));
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    // Host holds the request until it is taken
    task automatic send(input int d);
        req_valid = 1'b1;
        req_delay = D'(d);
        for (int i = 0; i < 64; i++) begin
            step();
            if (m_acc) break;
        end
        check("accept_timeout", 32'(m_acc), 32'd1);
        req_valid = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_delay = '0;
        idle(3);
        rst = 1'b0;
        idle(12);

        send(5);  idle(10);
        send(7);  idle(12);
        send(1);  idle(13);
        send(5);  idle(10);
        send(5);  idle(3);
        send(0);  idle(10);
        send(6);
        send(2);  idle(12);
        send(3);  idle(10);
        send(4);
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle(12);

        for (int i = 0; i < 1500; i++) begin
            rst       = ($urandom_range(0, 99) == 0);
            req_valid = ($urandom_range(0, 2) != 0);
            req_delay = D'($urandom_range(0, (2 ** D) - 1));
            step();
        end
        rst       = 1'b0;
        req_valid = 1'b0;
        idle(20);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
